// File: rtl/cfa_pkg.sv
// Shared constants for the CFA demosaic front end: FSM encoding, sample order
// within a cross, and default widths.
package cfa_pkg;

  localparam int DEF_PIX_W  = 12;
  localparam int DEF_GRAD_W = 8;

  localparam logic [1:0] ST_LOAD  = 2'd0;
  localparam logic [1:0] ST_CALC1 = 2'd1;
  localparam logic [1:0] ST_CALC2 = 2'd2;

  // Arrival order of the nine samples of one cross
  localparam logic [3:0] IDX_L2 = 4'd0;
  localparam logic [3:0] IDX_L1 = 4'd1;
  localparam logic [3:0] IDX_C  = 4'd2;
  localparam logic [3:0] IDX_R1 = 4'd3;
  localparam logic [3:0] IDX_R2 = 4'd4;
  localparam logic [3:0] IDX_U2 = 4'd5;
  localparam logic [3:0] IDX_U1 = 4'd6;
  localparam logic [3:0] IDX_D1 = 4'd7;
  localparam logic [3:0] IDX_D2 = 4'd8;

endpackage

// File: rtl/hv_grad_est_dir_grad.sv
// One-direction gradient and green estimate. Stage 1 (o_absd/o_lap/o_sum) and
// stage 2 (o_grad/o_g) are separate cones; the parent registers between them.
// Optional rounding: HV_GRAD_ROUND_EN.
module dir_grad
  import cfa_pkg::*;
#(
  parameter int PIX_W      = DEF_PIX_W,
  parameter int GRAD_W     = DEF_GRAD_W,
  parameter int GRAD_SHIFT = 4
) (
  input  logic [PIX_W-1:0]        i_far0,
  input  logic [PIX_W-1:0]        i_near0,
  input  logic [PIX_W-1:0]        i_centre,
  input  logic [PIX_W-1:0]        i_near1,
  input  logic [PIX_W-1:0]        i_far1,
  output logic [PIX_W-1:0]        o_absd,
  output logic signed [PIX_W+2:0] o_lap,
  output logic [PIX_W+2:0]        o_sum,
  input  logic [PIX_W-1:0]        i_absd,
  input  logic signed [PIX_W+2:0] i_lap,
  input  logic [PIX_W+2:0]        i_sum,
  output logic [GRAD_W-1:0]       o_grad,
  output logic [PIX_W:0]          o_g
);

  localparam int LW = PIX_W + 3;
  localparam int RW = PIX_W + 4;

`ifdef HV_GRAD_ROUND_EN
  localparam int G_RND = 2;
  localparam int H_RND = (GRAD_SHIFT > 0) ? (1 << (GRAD_SHIFT - 1)) : 0;
`else
  localparam int G_RND = 0;
  localparam int H_RND = 0;
`endif

  localparam logic [RW-1:0] GRAD_MAX = RW'((1 << GRAD_W) - 1);

  logic [LW-1:0]        w_lap_u;
  logic [LW-1:0]        w_abs_lap;
  logic [RW-1:0]        w_raw;
  logic [RW-1:0]        w_shr;
  logic signed [RW-1:0] w_num;
  logic signed [RW-1:0] w_q;

  assign o_absd  = (i_near0 >= i_near1) ? (i_near0 - i_near1) : (i_near1 - i_near0);
  // 2C - far0 - far1 wraps correctly in LW bits since the true value fits
  assign w_lap_u = {2'b00, i_centre, 1'b0} - LW'(i_far0) - LW'(i_far1);
  assign o_lap   = $signed(w_lap_u);
  assign o_sum   = (LW'(i_near0) + LW'(i_near1)) << 1;

  assign w_abs_lap = i_lap[LW-1] ? LW'(-i_lap) : LW'(i_lap);
  assign w_raw     = RW'(i_absd) + RW'(w_abs_lap) + RW'(H_RND);
  assign w_shr     = w_raw >> GRAD_SHIFT;
  assign o_grad    = (w_shr > GRAD_MAX) ? GRAD_W'(GRAD_MAX) : GRAD_W'(w_shr);

  // Numerator spans -2*max .. 6*max, so one extra sign bit over the sum
  assign w_num = $signed({1'b0, i_sum}) + $signed({i_lap[LW-1], i_lap}) + $signed(RW'(G_RND));
  assign w_q   = w_num >>> 2;
  assign o_g   = w_q[RW-1]             ? '0 :
                 (|w_q[RW-2:PIX_W])    ? {1'b0, {PIX_W{1'b1}}} :
                 w_q[PIX_W:0];

endmodule

// File: rtl/hv_grad_est.sv
// Horizontal/vertical gradient and directional green estimate for one
// missing-green site, fed serially by a 9-sample cross. Optional: HV_GRAD_ROUND_EN.
module hv_grad_est
  import cfa_pkg::*;
#(
  parameter int PIX_W      = DEF_PIX_W,
  parameter int GRAD_W     = DEF_GRAD_W,
  parameter int GRAD_SHIFT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [PIX_W-1:0]  pix_in,
  input  logic              pix_valid,
  output logic              pix_ready,
  output logic [GRAD_W-1:0] h,
  output logic [GRAD_W-1:0] v,
  output logic [PIX_W:0]    Gh,
  output logic [PIX_W:0]    Gv,
  output logic              ready,
  output logic [1:0]        o_dbg_state
);

  // Handshake: a sample moves on a rising edge where pix_valid && pix_ready;
  // pix_ready depends only on state, never on pix_valid.
  logic [1:0]             r_state;
  logic [3:0]             r_cnt;
  logic [PIX_W-1:0]       r_smp [9];
  logic                   w_acc;

  logic [PIX_W-1:0]        r_absd_h, r_absd_v;
  logic signed [PIX_W+2:0] r_lap_h, r_lap_v;
  logic [PIX_W+2:0]        r_sum_h, r_sum_v;

  logic [PIX_W-1:0]        w_absd_h, w_absd_v;
  logic signed [PIX_W+2:0] w_lap_h, w_lap_v;
  logic [PIX_W+2:0]        w_sum_h, w_sum_v;
  logic [GRAD_W-1:0]       w_grad_h, w_grad_v;
  logic [PIX_W:0]          w_g_h, w_g_v;

  assign pix_ready   = (r_state == ST_LOAD);
  assign w_acc       = pix_valid && pix_ready;
  assign o_dbg_state = r_state;

  dir_grad #(.PIX_W(PIX_W), .GRAD_W(GRAD_W), .GRAD_SHIFT(GRAD_SHIFT)) u_dir_h (
    .i_far0  (r_smp[IDX_L2]),
    .i_near0 (r_smp[IDX_L1]),
    .i_centre(r_smp[IDX_C]),
    .i_near1 (r_smp[IDX_R1]),
    .i_far1  (r_smp[IDX_R2]),
    .o_absd  (w_absd_h),
    .o_lap   (w_lap_h),
    .o_sum   (w_sum_h),
    .i_absd  (r_absd_h),
    .i_lap   (r_lap_h),
    .i_sum   (r_sum_h),
    .o_grad  (w_grad_h),
    .o_g     (w_g_h)
  );

  dir_grad #(.PIX_W(PIX_W), .GRAD_W(GRAD_W), .GRAD_SHIFT(GRAD_SHIFT)) u_dir_v (
    .i_far0  (r_smp[IDX_U2]),
    .i_near0 (r_smp[IDX_U1]),
    .i_centre(r_smp[IDX_C]),
    .i_near1 (r_smp[IDX_D1]),
    .i_far1  (r_smp[IDX_D2]),
    .o_absd  (w_absd_v),
    .o_lap   (w_lap_v),
    .o_sum   (w_sum_v),
    .i_absd  (r_absd_v),
    .i_lap   (r_lap_v),
    .i_sum   (r_sum_v),
    .o_grad  (w_grad_v),
    .o_g     (w_g_v)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= ST_LOAD;
      r_cnt    <= '0;
      for (int i = 0; i < 9; i++) r_smp[i] <= '0;
      r_absd_h <= '0;
      r_absd_v <= '0;
      r_lap_h  <= '0;
      r_lap_v  <= '0;
      r_sum_h  <= '0;
      r_sum_v  <= '0;
      h        <= '0;
      v        <= '0;
      Gh       <= '0;
      Gv       <= '0;
      ready    <= 1'b0;
    end else begin
      ready <= 1'b0;
      case (r_state)
        ST_LOAD: begin
          if (w_acc) begin
            r_smp[r_cnt] <= pix_in;
            if (r_cnt == IDX_D2) begin
              r_cnt   <= '0;
              r_state <= ST_CALC1;
            end else begin
              r_cnt <= r_cnt + 4'd1;
            end
          end
        end
        ST_CALC1: begin
          r_absd_h <= w_absd_h;
          r_absd_v <= w_absd_v;
          r_lap_h  <= w_lap_h;
          r_lap_v  <= w_lap_v;
          r_sum_h  <= w_sum_h;
          r_sum_v  <= w_sum_v;
          r_state  <= ST_CALC2;
        end
        ST_CALC2: begin
          h       <= w_grad_h;
          v       <= w_grad_v;
          Gh      <= w_g_h;
          Gv      <= w_g_v;
          ready   <= 1'b1;
          r_state <= ST_LOAD;
        end
        default: r_state <= ST_LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_hv_grad_est.sv
// Directed bench for hv_grad_est: hand-computed crosses, exact ready timing,
// valid gaps, and a reset that aborts a partial cross.
module tb_hv_grad_est;
  import cfa_pkg::*;

  localparam int PIX_W  = 12;
  localparam int GRAD_W = 8;

`ifdef HV_GRAD_ROUND_EN
  localparam int EXP_H2   = 13;
  localparam int EXP_GV4  = 3074;
  localparam int EXP_GH5  = 1024;
`else
  localparam int EXP_H2   = 12;
  localparam int EXP_GV4  = 3073;
  localparam int EXP_GH5  = 1023;
`endif

  logic              clk;
  logic              rst;
  logic [PIX_W-1:0]  pix_in;
  logic              pix_valid;
  logic              pix_ready;
  logic [GRAD_W-1:0] h;
  logic [GRAD_W-1:0] v;
  logic [PIX_W:0]    Gh;
  logic [PIX_W:0]    Gv;
  logic              ready;
  logic [1:0]        dbg_state;

  int n_vec  = 0;
  int n_fail = 0;
  int n_ready = 0;
  logic [PIX_W-1:0] vec [9];

  hv_grad_est dut (
    .clk        (clk),
    .rst        (rst),
    .pix_in     (pix_in),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .h          (h),
    .v          (v),
    .Gh         (Gh),
    .Gv         (Gv),
    .ready      (ready),
    .o_dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (rst && ready) n_ready++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_vec(input int a0, a1, a2, a3, a4, a5, a6, a7, a8);
    vec[0] = a0[PIX_W-1:0]; vec[1] = a1[PIX_W-1:0]; vec[2] = a2[PIX_W-1:0];
    vec[3] = a3[PIX_W-1:0]; vec[4] = a4[PIX_W-1:0]; vec[5] = a5[PIX_W-1:0];
    vec[6] = a6[PIX_W-1:0]; vec[7] = a7[PIX_W-1:0]; vec[8] = a8[PIX_W-1:0];
  endtask

  // Drive the first n samples of vec; optional random idle gaps between them.
  task automatic send_n(input int n, input bit gaps);
    bit acc;
    int tries;
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        int g = $urandom_range(0, 2);
        for (int k = 0; k < g; k++) begin
          @(negedge clk);
          pix_valid = 1'b0;
          pix_in    = PIX_W'($urandom_range(0, 4095));
        end
      end
      acc   = 1'b0;
      tries = 0;
      while (!acc && tries < 20) begin
        @(negedge clk);
        pix_valid = 1'b1;
        pix_in    = vec[i];
        acc       = pix_ready;
        tries++;
        @(posedge clk);
      end
      if (!acc) chk("accept_timeout", 32'(tries), 32'(0));
    end
  endtask

  // Called right after the 9th accepting edge k; pix_valid stays high with junk
  // through CALC1/CALC2 and must not be consumed.
  task automatic expect_result(input string tag, input int eh, ev, egh, egv);
    @(negedge clk);
    pix_in = PIX_W'($urandom_range(0, 4095));
    chk({tag, "_rdy_c1"}, ready, 0);
    chk({tag, "_prdy_c1"}, pix_ready, 0);
    chk({tag, "_st_c1"}, dbg_state, ST_CALC1);
    @(negedge clk);
    chk({tag, "_rdy_c2"}, ready, 0);
    chk({tag, "_prdy_c2"}, pix_ready, 0);
    @(negedge clk);
    pix_valid = 1'b0;
    chk({tag, "_rdy"}, ready, 1);
    chk({tag, "_prdy"}, pix_ready, 1);
    chk({tag, "_h"}, h, eh);
    chk({tag, "_v"}, v, ev);
    chk({tag, "_Gh"}, Gh, egh);
    chk({tag, "_Gv"}, Gv, egv);
    @(negedge clk);
    chk({tag, "_rdy_drop"}, ready, 0);
    chk({tag, "_h_hold"}, h, eh);
    chk({tag, "_Gv_hold"}, Gv, egv);
  endtask

  initial begin
    int saved_ready;
    rst       = 1'b0;
    pix_in    = '0;
    pix_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_h", h, 0);
    chk("rst_v", v, 0);
    chk("rst_Gh", Gh, 0);
    chk("rst_Gv", Gv, 0);
    chk("rst_ready", ready, 0);
    chk("rst_prdy", pix_ready, 1);
    chk("rst_state", dbg_state, ST_LOAD);
    rst = 1'b1;
    @(negedge clk);

    // order: L2 L1 C R1 R2 U2 U1 D1 D2
    set_vec(100, 100, 100, 100, 100, 100, 100, 100, 100);
    send_n(9, 1'b0);
    expect_result("flat", 0, 0, 100, 100);

    set_vec(0, 0, 100, 200, 200, 100, 100, 100, 100);
    send_n(9, 1'b0);
    expect_result("hramp", EXP_H2, 0, 100, 100);

    set_vec(4095, 0, 0, 0, 4095, 0, 0, 0, 0);
    send_n(9, 1'b1);
    expect_result("neg_clamp", 255, 0, 0, 0);

    set_vec(0, 4095, 4095, 4095, 0, 4000, 3000, 3100, 4095);
    send_n(9, 1'b0);
    expect_result("pos_clamp", 255, 12, 4095, EXP_GV4);

    set_vec(0, 4095, 0, 0, 4095, 0, 0, 0, 0);
    send_n(9, 1'b1);
    expect_result("floor", 255, 0, EXP_GH5, 0);

    set_vec(500, 500, 500, 500, 500, 100, 300, 700, 900);
    send_n(9, 1'b0);
    expect_result("vgrad", 0, 25, 500, 500);

    // abort a partial cross with reset after the 5th sample
    saved_ready = n_ready;
    set_vec(4095, 7, 3000, 9, 4095, 1, 2, 3, 4);
    send_n(5, 1'b1);
    @(negedge clk);
    pix_valid = 1'b0;
    rst       = 1'b0;
    @(negedge clk);
    chk("abort_h", h, 0);
    chk("abort_Gh", Gh, 0);
    chk("abort_ready", ready, 0);
    chk("abort_state", dbg_state, ST_LOAD);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("abort_no_ready", n_ready, saved_ready);

    set_vec(100, 100, 100, 100, 100, 100, 100, 100, 100);
    send_n(9, 1'b1);
    expect_result("post_abort", 0, 0, 100, 100);
    chk("ready_count", n_ready, saved_ready + 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=1 expected=0");
    $fatal(1, "timeout");
  end

endmodule
